// File: rtl/kernel_job_ctrl.sv
// Job sequencer for a streaming kernel: gates per-channel input words and
// kernel output words, counts both, and reports done one cycle after the last output.
module kernel_job_ctrl #(
    parameter int C_NUM_CHANNELS = 2,
    parameter int CNT_W          = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      ap_start,
    input  logic [CNT_W-1:0]          job_len,
    output logic                      ap_idle,
    output logic                      ap_busy,
    output logic                      ap_done,
    input  logic [C_NUM_CHANNELS-1:0] s_tvalid,
    output logic [C_NUM_CHANNELS-1:0] s_tready,
    output logic                      k_ivalid,
    input  logic                      k_iready,
    input  logic                      k_ovalid,
    output logic                      k_oready,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic [CNT_W-1:0]          in_count,
    output logic [CNT_W-1:0]          out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] in_q, in_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             in_fire, out_fire, out_ok;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            len_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // Inputs are taken only when every channel has a word at once.
    assign k_ivalid = (&s_tvalid) && (state_q == RUN) && (in_q < len_q);
    assign in_fire  = k_ivalid && k_iready;
    assign s_tready = {C_NUM_CHANNELS{in_fire}};

    assign out_ok   = ((state_q == RUN) || (state_q == DRAIN)) && (out_q < len_q);
    assign m_tvalid = k_ovalid && out_ok;
    assign k_oready = m_tready && out_ok;
    assign out_fire = m_tvalid && m_tready;
    assign m_tlast  = m_tvalid && (out_q == len_q - ONE);

    assign ap_idle   = (state_q == IDLE);
    assign ap_busy   = (state_q == RUN) || (state_q == DRAIN);
    assign ap_done   = (state_q == DONE);
    assign in_count  = in_q;
    assign out_count = out_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        in_d    = in_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    len_d   = job_len;
                    in_d    = '0;
                    out_d   = '0;
                    state_d = (job_len == '0) ? DONE : RUN;
                end
            end
            RUN, DRAIN: begin
                if (in_fire)  in_d  = in_q + ONE;
                if (out_fire) out_d = out_q + ONE;
                // Last output wins even if the last input lands on the same edge.
                if (out_d == len_q)     state_d = DONE;
                else if (in_d == len_q) state_d = DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kernel_job_ctrl.sv
// Bench for kernel_job_ctrl: directed scenarios plus random handshakes,
// checked every cycle against a job-level reference model.
module tb_kernel_job_ctrl;

    localparam int NC = 2;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ap_start;
    logic [CW-1:0] job_len;
    logic          ap_idle, ap_busy, ap_done;
    logic [NC-1:0] s_tvalid, s_tready;
    logic          k_ivalid, k_iready;
    logic          k_ovalid, k_oready;
    logic          m_tvalid, m_tready, m_tlast;
    logic [CW-1:0] in_count, out_count;

    kernel_job_ctrl #(.C_NUM_CHANNELS(NC), .CNT_W(CW)) dut (
        .aclk(aclk), .areset(areset),
        .ap_start(ap_start), .job_len(job_len),
        .ap_idle(ap_idle), .ap_busy(ap_busy), .ap_done(ap_done),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .k_ivalid(k_ivalid), .k_iready(k_iready),
        .k_ovalid(k_ovalid), .k_oready(k_oready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;

    // Reference model: job phase flags and word counts.
    bit      m_idle, m_busy, m_done;
    longint  m_len, m_in, m_out;
    int      cyc = 0;
    int      kq[$];
    bit      force_kov = 0;
    bit      seen_last;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_idle = 1; m_busy = 0; m_done = 0;
        m_len = 0; m_in = 0; m_out = 0;
        kq.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_idle", ap_idle, 1);
        chk("rst_busy", ap_busy, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_stready", s_tready, 0);
        chk("rst_kivalid", k_ivalid, 0);
        chk("rst_koready", k_oready, 0);
        chk("rst_mtvalid", m_tvalid, 0);
        chk("rst_mtlast", m_tlast, 0);
        chk("rst_incnt", in_count, 0);
        chk("rst_outcnt", out_count, 0);
    endtask

    task automatic step(bit st, longint jl, logic [NC-1:0] sv, bit kir, bit mtr);
        bit e_iv, e_ov, e_or, ifire, ofire;
        ap_start = st;
        job_len  = CW'(jl);
        s_tvalid = sv;
        k_iready = kir;
        m_tready = mtr;
        k_ovalid = force_kov || (kq.size() > 0 && cyc - kq[0] >= 3);
        @(negedge aclk);
        e_iv = m_busy && (&sv) && (m_in < m_len);
        e_ov = m_busy && k_ovalid && (m_out < m_len);
        e_or = m_busy && mtr && (m_out < m_len);
        ifire = e_iv && kir;
        ofire = e_ov && mtr;
        chk("ap_idle", ap_idle, m_idle);
        chk("ap_busy", ap_busy, m_busy);
        chk("ap_done", ap_done, m_done);
        chk("k_ivalid", k_ivalid, e_iv);
        chk("s_tready", s_tready, ifire ? {NC{1'b1}} : '0);
        chk("m_tvalid", m_tvalid, e_ov);
        chk("k_oready", k_oready, e_or);
        chk("m_tlast", m_tlast, e_ov && (m_out == m_len - 1));
        chk("in_count", in_count, m_in);
        chk("out_count", out_count, m_out);
        if (e_ov && (m_out == m_len - 1) && mtr) seen_last = 1;
        @(posedge aclk);
        #1;
        if (m_done) begin
            m_done = 0; m_idle = 1;
        end else if (m_idle) begin
            if (st) begin
                m_in = 0; m_out = 0; m_idle = 0;
                if (jl == 0) m_done = 1;
                else begin m_busy = 1; m_len = jl; end
            end
        end else if (m_busy) begin
            if (ifire) m_in++;
            if (ofire) m_out++;
            if (m_out == m_len) begin m_busy = 0; m_done = 1; end
        end
        if (ofire && kq.size() > 0) void'(kq.pop_front());
        if (ifire) kq.push_back(cyc);
        cyc++;
    endtask

    // mode 0: all ones, 1: random, 2: m_tready toggles
    task automatic run_job(longint jl, int mode, int budget);
        int n = 0;
        bit tg = 1;
        seen_last = 0;
        step(1, jl, '1, 1, 1);
        while (!m_idle && n < budget) begin
            if (mode == 0) step(0, 0, '1, 1, 1);
            else if (mode == 1)
                step(0, $urandom, NC'($urandom), 1'($urandom), 1'($urandom));
            else begin
                step(0, 0, '1, 1, tg);
                tg = ~tg;
            end
            n++;
        end
        if (!m_idle) begin
            total++;
            $error("FAIL job_timeout observed=%0d expected=<%0d", n, budget);
        end
    endtask

    initial begin
        areset = 1; ap_start = 0; job_len = 0;
        s_tvalid = 0; k_iready = 0; m_tready = 0; k_ovalid = 0;
        model_reset();
        #2;
        chk_reset_vals();
        @(posedge aclk); #1;
        areset = 0;

        // Full-throughput job of 4, kernel latency 3.
        run_job(4, 0, 40);
        chk("j4_in", in_count, 4);
        chk("j4_out", out_count, 4);
        chk("j4_last_seen", seen_last, 1);

        // One channel missing for 5 cycles stalls the whole input.
        step(1, 3, '1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 2'b01, 1, 1);
        chk("stall_in", in_count, 0);
        for (int i = 0; i < 40 && !m_idle; i++) step(0, 0, 2'b11, 1, 1);
        chk("stall_done_in", in_count, 3);

        // m_tready toggling; kernel keeps k_ovalid high afterwards.
        run_job(3, 2, 60);
        chk("tog_out", out_count, 3);
        force_kov = 1;
        for (int i = 0; i < 3; i++) step(0, 0, '1, 1, 1);
        force_kov = 0;
        chk("tog_no4th", out_count, 3);

        // Zero-length job goes straight to done.
        step(1, 0, '1, 1, 1);
        chk("zero_done", ap_done, 1);
        step(0, 0, '1, 1, 1);
        step(0, 0, '1, 1, 1);

        // Restart with a new length mid-job is ignored.
        step(1, 5, '1, 1, 1);
        step(0, 0, '1, 1, 1);
        step(1, 9, '1, 1, 1);
        for (int i = 0; i < 40 && !m_idle; i++) step(1, 9, '1, 1, 1);
        chk("restart_ign_out", out_count, 5);
        ap_start = 0;
        step(0, 0, '1, 1, 1);
        chk("restart_ign_idle", ap_idle, 1);

        // Reset after two of six inputs aborts the job.
        step(1, 6, '1, 1, 1);
        for (int i = 0; i < 10 && m_in < 2; i++) step(0, 0, '1, 1, 1);
        chk("pre_rst_in", in_count, 2);
        areset = 1; ap_start = 0;
        #1;
        chk_reset_vals();
        model_reset();
        @(posedge aclk); #1;
        chk_reset_vals();
        areset = 0;
        run_job(2, 0, 30);
        chk("post_rst_out", out_count, 2);

        // Random handshakes over random lengths.
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(1, 12), 1, 400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
